// File: rtl/chunked_add_sequencer_if.sv
// chunked_add_sequencer_if: request, datapath and result signals of the chunked add sequencer
interface chunked_add_sequencer_if #(parameter int WIDTH = 64, parameter int CHUNK = 16);
  logic in_valid, in_ready, in_cin, in_sub;
  logic [WIDTH-1:0] in_a, in_b;
  logic [CHUNK-1:0] dp_a, dp_b, dp_sum;
  logic dp_cn, dp_cout;
  logic out_valid, out_ready, out_cout, out_ovf;
  logic [WIDTH-1:0] out_sum;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready, dp_sum, dp_cout,
    input  in_ready, dp_a, dp_b, dp_cn, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready, dp_sum, dp_cout,
    output in_ready, dp_a, dp_b, dp_cn, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer: WIDTH-bit add/subtract sequenced LS chunk first over an external CHUNK-bit adder
module chunked_add_sequencer #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic clk,
  input logic rst,
  chunked_add_sequencer_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic carry, run, last, accept;
  logic [WIDTH-1:0] a_r, b_r;
  // B is stored already inverted for subtract, so the datapath only ever adds
  always_comb begin
    run = state == RUN;
    last = idx == IW'(NCH - 1);
    accept = state == IDLE && bus.in_valid;
    state_nxt = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? HOLD : RUN) :
                                (bus.out_ready ? IDLE : HOLD);
    bus.in_ready = state == IDLE;
    bus.out_valid = state == HOLD;
    bus.dp_a = run ? a_r[idx*CHUNK +: CHUNK] : '0;
    bus.dp_b = run ? b_r[idx*CHUNK +: CHUNK] : '0;
    bus.dp_cn = run & carry;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      bus.out_sum <= '0;
      bus.out_cout <= 1'b0;
      bus.out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_r <= bus.in_a;
        b_r <= bus.in_b ^ {WIDTH{bus.in_sub}};
        carry <= bus.in_cin ^ bus.in_sub;
        idx <= '0;
      end
      if (run) begin
        bus.out_sum[idx*CHUNK +: CHUNK] <= bus.dp_sum;
        carry <= bus.dp_cout;
        idx <= idx + 1'b1;
        if (last) begin
          bus.out_cout <= bus.dp_cout;
          bus.out_ovf <= (bus.dp_a[CHUNK-1] == bus.dp_b[CHUNK-1]) && (bus.dp_sum[CHUNK-1] != bus.dp_a[CHUNK-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// tb_chunked_add_sequencer: directed tests against a behavioural 16-bit adder datapath
module tb_chunked_add_sequencer;
  logic clk = 0, rst = 1;
  int n_checks = 0, n_fail = 0;
  chunked_add_sequencer_if #(.WIDTH(64), .CHUNK(16)) bus();
  chunked_add_sequencer #(.WIDTH(64), .CHUNK(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign {bus.dp_cout, bus.dp_sum} = {1'b0, bus.dp_a} + {1'b0, bus.dp_b} + {16'd0, bus.dp_cn};

  logic [3:0] cn;
  logic [15:0] b0;
  int lat;

  // starts at a negedge, returns at the negedge where out_valid is first seen
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub, input logic junk);
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub; bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = junk;
    bus.in_a = 64'h0BAD_0BAD_0BAD_0BAD; bus.in_b = 64'h1234_5678_9ABC_DEF0; bus.in_cin = ~cin; bus.in_sub = ~sub;
    cn = 'x; b0 = 'x; lat = 99;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) begin lat = k; break; end
      if (k < 4) cn[k] = bus.dp_cn;
      if (k == 0) b0 = bus.dp_b;
      @(negedge clk);
    end
    bus.in_valid = 0;
  endtask

  task automatic release_op();
    bus.out_ready = 1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    bus.out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; bus.in_valid = 0; bus.out_ready = 0;
    bus.in_a = 0; bus.in_b = 0; bus.in_cin = 0; bus.in_sub = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    n_checks++; if (bus.out_sum !== 64'd0 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out: sum=%h cout=%b ovf=%b want 0", bus.out_sum, bus.out_cout, bus.out_ovf); end
    n_checks++; if (bus.dp_a !== 16'd0 || bus.dp_b !== 16'd0 || bus.dp_cn !== 1'b0) begin n_fail++; $display("FAIL reset_dp: a=%h b=%h cn=%b want 0", bus.dp_a, bus.dp_b, bus.dp_cn); end
    rst = 0;
  endtask

  task automatic test_add();
    run_op(64'h0000_0000_0000_FFFF, 64'd1, 0, 0, 0);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_checks++; if (bus.out_sum !== 64'h0000_0000_0001_0000) begin n_fail++; $display("FAIL add_sum: got %h want 0000000000010000", bus.out_sum); end
    n_checks++; if (bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL add_flags: cout=%b ovf=%b want 0/0", bus.out_cout, bus.out_ovf); end
    n_checks++; if (cn !== 4'b0010) begin n_fail++; $display("FAIL add_cn: got %b want 0010", cn); end
    release_op();
  endtask

  task automatic test_ripple();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 0);
    n_checks++; if (bus.out_sum !== 64'd0) begin n_fail++; $display("FAIL ripple_sum: got %h want 0", bus.out_sum); end
    n_checks++; if (bus.out_cout !== 1'b1 || bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL ripple_flags: cout=%b ovf=%b want 1/0", bus.out_cout, bus.out_ovf); end
    n_checks++; if (cn !== 4'b1111) begin n_fail++; $display("FAIL ripple_cn: got %b want 1111", cn); end
    release_op();
  endtask

  task automatic test_sub();
    run_op(64'd5, 64'd7, 0, 1, 0);
    n_checks++; if (bus.out_sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub_sum: got %h want fffffffffffffffe", bus.out_sum); end
    n_checks++; if (bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL sub_flags: cout=%b ovf=%b want 0/0", bus.out_cout, bus.out_ovf); end
    n_checks++; if (cn[0] !== 1'b1 || b0 !== 16'hFFF8) begin n_fail++; $display("FAIL sub_chunk0: cn=%b b=%h want 1/fff8", cn[0], b0); end
    release_op();
  endtask

  task automatic test_overflow();
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0);
    n_checks++; if (bus.out_sum !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL ovf_sum: got %h want 8000000000000000", bus.out_sum); end
    n_checks++; if (bus.out_ovf !== 1'b1 || bus.out_cout !== 1'b0) begin n_fail++; $display("FAIL ovf_flags: ovf=%b cout=%b want 1/0", bus.out_ovf, bus.out_cout); end
    release_op();
  endtask

  task automatic test_backpressure();
    run_op(64'h0000_0000_0000_1234, 64'h0000_0000_0000_1111, 0, 0, 1);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d want 4", lat); end
    bus.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== 64'h2345 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b ready=%b sum=%h cout=%b ovf=%b want 1/0/2345/0/0", i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_cout, bus.out_ovf);
      end
      @(negedge clk);
    end
    bus.out_ready = 1; bus.in_a = 64'd10; bus.in_b = 64'd20; bus.in_cin = 0; bus.in_sub = 0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_to_idle: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    bus.out_ready = 0;
    run_op(64'd10, 64'd20, 0, 0, 0);
    n_checks++; if (lat !== 4 || bus.out_sum !== 64'd30) begin n_fail++; $display("FAIL bp_next_op: lat=%0d sum=%h want 4/1e", lat, bus.out_sum); end
    release_op();
  endtask

  task automatic test_reset_mid();
    bus.in_a = 64'h1111_2222_3333_4444; bus.in_b = 64'd1; bus.in_cin = 0; bus.in_sub = 0; bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.dp_a !== 16'h2222) begin n_fail++; $display("FAIL mid_chunk2: dp_a=%h want 2222", bus.dp_a); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hs: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    n_checks++; if (bus.dp_a !== 16'd0 || bus.dp_b !== 16'd0 || bus.dp_cn !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dp: a=%h b=%h cn=%b want 0", bus.dp_a, bus.dp_b, bus.dp_cn); end
    run_op(64'd3, 64'd4, 0, 0, 0);
    n_checks++; if (lat !== 4 || bus.out_sum !== 64'd7 || bus.out_cout !== 1'b0) begin n_fail++; $display("FAIL mid_next_op: lat=%0d sum=%h cout=%b want 4/7/0", lat, bus.out_sum, bus.out_cout); end
    release_op();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ripple();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
